// File: rtl/hazard_pipeline_ctrl.sv
// hazard_pipeline_ctrl
// Central sequencer for the 5-stage MIPS pipeline. It produces the load
// enables and synchronous clears for PC, IF_ID, ID_EX, EX_MEM and MEM_WB.
// It also schedules the multi-cycle mult/div unit that writes HI/LO.
//
// Handshake with the mult/div unit:
//   MD_Start is a one-cycle request, qualified by MD_IsDiv.
//   The unit is assumed always ready when this block is in RUN.
//   The unit then owns HI/LO until the MD_Done pulse. MD_Done marks the
//   cycle in which HI/LO is written.
//   MD_Busy is high in every cycle after MD_Start, up to and including the
//   MD_Done cycle.
//
// Pipeline control priority, highest first:
//   reset, Mem_Stall (freeze), EX_BranchTaken (flush), load-use / HI-LO hold
//   (bubble), then normal advance.
module hazard_pipeline_ctrl #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 8,
  parameter int CNT_W       = 4
) (
  input  logic       Clk,
  input  logic       Clr_n,
  input  logic [4:0] ID_Rs,
  input  logic [4:0] ID_Rt,
  input  logic       ID_UsesRt,
  input  logic       ID_MulDiv,
  input  logic       ID_IsDiv,
  input  logic       ID_ReadsHiLo,
  input  logic       EX_MemRead,
  input  logic [4:0] EX_RegDstData,
  input  logic       EX_BranchTaken,
  input  logic       Mem_Stall,
  output logic       PC_Ld,
  output logic       IF_ID_Ld,
  output logic       ID_EX_Ld,
  output logic       EX_MEM_Ld,
  output logic       MEM_WB_Ld,
  output logic       IF_ID_Clr,
  output logic       ID_EX_Clr,
  output logic       EX_MEM_Clr,
  output logic       MEM_WB_Clr,
  output logic       MD_Start,
  output logic       MD_IsDiv,
  output logic       MD_Busy,
  output logic       MD_Done,
  output logic       dbg_state
);

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } state_t;

  // The counter is loaded with the cycle count minus one. It reaches zero
  // in the MD_Done cycle.
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  logic loaduse;
  logic hilo_hold;
  logic md_start_int;

  assign dbg_state = state;

  // Hazard detection. A load in EX whose destination matches an ID source
  // cannot be forwarded in time. The match ignores register $zero.
  always_comb begin
    loaduse   = EX_MemRead && (EX_RegDstData != 5'd0) &&
                ((EX_RegDstData == ID_Rs) ||
                 (ID_UsesRt && (EX_RegDstData == ID_Rt)));
    // The hold covers the MD_Done cycle, because HI/LO is written at the
    // end of that cycle.
    hilo_hold = (state == MD_BUSY) && (ID_ReadsHiLo || ID_MulDiv);
  end

  // Pipeline register controls and the mult/div issue decision.
  always_comb begin
    PC_Ld        = 1'b1;
    IF_ID_Ld     = 1'b1;
    ID_EX_Ld     = 1'b1;
    EX_MEM_Ld    = 1'b1;
    MEM_WB_Ld    = 1'b1;
    IF_ID_Clr    = 1'b0;
    ID_EX_Clr    = 1'b0;
    EX_MEM_Clr   = 1'b0;
    MEM_WB_Clr   = 1'b0;
    md_start_int = 1'b0;

    if (!Clr_n) begin
      PC_Ld      = 1'b0;
      IF_ID_Ld   = 1'b0;
      ID_EX_Ld   = 1'b0;
      EX_MEM_Ld  = 1'b0;
      MEM_WB_Ld  = 1'b0;
      IF_ID_Clr  = 1'b1;
      ID_EX_Clr  = 1'b1;
      EX_MEM_Clr = 1'b1;
      MEM_WB_Clr = 1'b1;
    end else if (Mem_Stall) begin
      // Freeze everything. EX still holds any taken branch, so the flush
      // happens in the first cycle after the stall.
      PC_Ld     = 1'b0;
      IF_ID_Ld  = 1'b0;
      ID_EX_Ld  = 1'b0;
      EX_MEM_Ld = 1'b0;
      MEM_WB_Ld = 1'b0;
    end else if (EX_BranchTaken) begin
      // Squash IF and ID. The ID instruction never issues, so a mult/div
      // in ID does not start.
      IF_ID_Clr = 1'b1;
      ID_EX_Clr = 1'b1;
    end else if (loaduse || hilo_hold) begin
      // Hold PC and IF_ID, and send a bubble into EX.
      PC_Ld     = 1'b0;
      IF_ID_Ld  = 1'b0;
      ID_EX_Clr = 1'b1;
    end else begin
      md_start_int = ID_MulDiv && (state == RUN);
    end
  end

  // Mult/div unit handshake outputs.
  always_comb begin
    MD_Start = md_start_int;
    MD_IsDiv = md_start_int && ID_IsDiv;
    MD_Busy  = Clr_n && (state == MD_BUSY);
    MD_Done  = Clr_n && (state == MD_BUSY) && (cnt == '0);
  end

  // Next-state logic. The counter keeps running through Mem_Stall and
  // through flushes, because the operation belongs to an older instruction.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      RUN: begin
        if (md_start_int) begin
          state_nxt = MD_BUSY;
          cnt_nxt   = ID_IsDiv ? DIV_LOAD : MULT_LOAD;
        end
      end
      MD_BUSY: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
        end else begin
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = RUN;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State register. Reset aborts any operation in flight, so no MD_Done
  // is produced for it.
  always_ff @(posedge Clk or negedge Clr_n) begin
    if (!Clr_n) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

endmodule

// File: doc/hazard_pipeline_ctrl.md
Name: hazard_pipeline_ctrl

Overview:
- Central sequencer for the 5-stage MIPS pipeline.
- Drives the Ld/Clr controls of PC, IF_ID, ID_EX, EX_MEM and MEM_WB, inserting stalls, bubbles and flushes.
- Schedules the multi-cycle mult/div unit that produces HI/LO, and holds HI/LO readers and second mult/div issues until the result is written.

Parameters:
- MULT_CYCLES, 4, cycles the mult unit is busy per mult/multu (≥1).
- DIV_CYCLES, 8, cycles the div unit is busy per div/divu (≥1).
- CNT_W, 4, busy counter width; must hold max(MULT_CYCLES, DIV_CYCLES)-1.

Ports:
- Clk  in  1  clock, rising edge.
- Clr_n  in  1  asynchronous active-low reset.
- ID_Rs  in  5  source register of the instruction in ID.
- ID_Rt  in  5  second source register of the instruction in ID.
- ID_UsesRt  in  1  the instruction in ID reads Rt.
- ID_MulDiv  in  1  the instruction in ID is mult/multu/div/divu.
- ID_IsDiv  in  1  qualifies ID_MulDiv: 1 = div class.
- ID_ReadsHiLo  in  1  the instruction in ID is mfhi/mflo.
- EX_MemRead  in  1  the instruction in EX is a load.
- EX_RegDstData  in  5  destination register of the instruction in EX.
- EX_BranchTaken  in  1  branch/jump resolved taken in EX.
- Mem_Stall  in  1  data memory not ready; freeze the whole pipeline.
- PC_Ld, IF_ID_Ld, ID_EX_Ld, EX_MEM_Ld, MEM_WB_Ld  out  1 each  register load enables.
- IF_ID_Clr, ID_EX_Clr, EX_MEM_Clr, MEM_WB_Clr  out  1 each  synchronous clears (bubble insertion).
- MD_Start  out  1  one-cycle start pulse to the mult/div unit.
- MD_IsDiv  out  1  operation select, valid with MD_Start.
- MD_Busy  out  1  mult/div operation in progress.
- MD_Done  out  1  one-cycle pulse: HI/LO write this cycle.

Behaviour:
- State: RUN, MD_BUSY. Busy counter cnt[CNT_W-1:0]. Registers are asynchronously cleared by Clr_n low: state = RUN, cnt = 0.
- While Clr_n is low: all *_Ld = 0, all *_Clr = 1, MD_Start = MD_IsDiv = MD_Busy = MD_Done = 0.
- Outputs are combinational from the inputs and registered state, so a stall takes effect in the same cycle.
- Defaults: all Ld = 1, all Clr = 0.
- loaduse = EX_MemRead & (EX_RegDstData != 0) & ((EX_RegDstData == ID_Rs) | (ID_UsesRt & EX_RegDstData == ID_Rt)).
- hilo_hold = (state == MD_BUSY) & (ID_ReadsHiLo | ID_MulDiv). This includes the MD_Done cycle.
- Priority 1, Mem_Stall = 1:
  - all Ld = 0, all Clr = 0, MD_Start = 0.
  - EX_BranchTaken is ignored this cycle; it stays asserted because EX holds.
  - cnt and state continue to advance; the mult/div unit runs independently.
- Priority 2, EX_BranchTaken = 1:
  - PC_Ld = 1, IF_ID_Clr = 1, ID_EX_Clr = 1.
  - loaduse and hilo_hold are ignored.
  - MD_Start = 0, since the ID instruction is squashed.
- Priority 3, loaduse | hilo_hold:
  - PC_Ld = 0, IF_ID_Ld = 0, ID_EX_Clr = 1 (bubble).
  - EX_MEM and MEM_WB advance.
- Issue rule: MD_Start = ID_MulDiv & state == RUN & none of priorities 1–3 apply. MD_IsDiv = ID_IsDiv when MD_Start = 1, else 0.
- On MD_Start: next state = MD_BUSY; cnt loads (ID_IsDiv ? DIV_CYCLES : MULT_CYCLES) - 1.
- In MD_BUSY:
  - MD_Busy = 1.
  - cnt != 0: cnt decrements each cycle.
  - cnt == 0: MD_Done = 1 and next state = RUN.
- A start at cycle t gives MD_Busy during t+1..t+N and MD_Done at t+N.
- A mult/div or mfhi/mflo in ID during MD_BUSY proceeds in the cycle after MD_Done, with no extra gap.
- Simultaneous events:
  - Mem_Stall with a pending start: the start is deferred to the first cycle Mem_Stall = 0.
  - Flush during MD_BUSY does not abort the operation; the issued instruction was older than the branch.
- Reset mid-operation: asynchronously aborts the busy state; no MD_Done is emitted.

Test Plan:
1. Reset: Clr_n = 0 for 3 cycles with random inputs -> all Ld = 0, all Clr = 1, MD_* = 0. After release with idle inputs -> all Ld = 1, all Clr = 0.
2. Load-use: EX_MemRead = 1, EX_RegDstData = 8, ID_Rs = 8 -> PC_Ld = IF_ID_Ld = 0, ID_EX_Clr = 1 for exactly that cycle. Repeat with EX_RegDstData = 0 -> no stall. Repeat with ID_Rt = 8, ID_UsesRt = 0 -> no stall.
3. Branch priority: EX_BranchTaken = 1 together with a load-use match and ID_MulDiv = 1 -> IF_ID_Clr = ID_EX_Clr = 1, PC_Ld = 1, MD_Start = 0.
4. Mult timing: ID_MulDiv = 1, ID_IsDiv = 0 at cycle 10 -> MD_Start at 10, MD_Busy during 11–14, MD_Done at 14. mflo held in ID during 11–14 (ID_EX_Clr = 1), issues at 15.
5. Back-to-back div: div at cycle 0, second div waiting in ID -> MD_Done at 8, second MD_Start at 9 with MD_IsDiv = 1.
6. Mem_Stall: assert during MD_BUSY and together with EX_BranchTaken -> all Ld = 0, no Clr, MD_Done still at the scheduled cycle. Flush occurs in the first cycle after Mem_Stall drops. Asserting Clr_n = 0 mid-div -> MD_Busy drops immediately, no MD_Done.
